// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 encodings, FSM states and operand-signedness helpers.
package ex_muldiv_unit_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic rs1_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic rs2_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_core.sv
// Iterative datapath: 64-bit accumulator doing one shift-add (multiply) or
// one restoring subtract (divide) step per cycle on operand magnitudes.
module muldiv_iter_core
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_nxt_o,
  output logic              last_o
);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [XLEN-1:0]   b_q, b_d;
  logic              div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     sum, rem_sh, diff;

  always_comb begin
    // Multiply: acc = {partial_hi, remaining multiplier bits}, shifted right.
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Divide: acc = {remainder, dividend/quotient bits}, shifted left.
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, b_q};
    if (div_q) begin
      acc_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {sum, acc_q[XLEN-1:1]};
    end

    acc_d = acc_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, a_i};
      b_d   = b_i;
      div_d = is_div_i;
      cnt_d = '0;
    end else if (step_i) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CNT_W'(1);
    end

    acc_nxt_o = acc_step;
    last_o    = (cnt_q == CNT_W'(XLEN-1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: control FSM, operand sign handling, fast-path
// detection for divide-by-zero / signed overflow, and pipeline stall/flush.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN      = MD_XLEN,
  parameter int CNT_W     = 6,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d, op_in;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d, rs1_q, rs1_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;
  logic              s1, s2, div0, ovf, fast, accept, last;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc_nxt;

  function automatic logic [XLEN-1:0] fix_sign(
    input md_op_e op, input logic [2*XLEN-1:0] acc, input logic qneg,
    input logic rneg, input logic dz, input logic [XLEN-1:0] dividend);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = qneg ? -acc : acc;
    quo  = qneg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = rneg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      MD_MUL:                       return prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: return prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              return dz ? '1 : quo;
      default:                      return dz ? dividend : rem;
    endcase
  endfunction

  always_comb begin
    op_in  = md_op_e'(op_i);
    s1     = rs1_signed(op_in) & rs1_data_i[XLEN-1];
    s2     = rs2_signed(op_in) & rs2_data_i[XLEN-1];
    a_mag  = s1 ? -rs1_data_i : rs1_data_i;
    b_mag  = s2 ? -rs2_data_i : rs2_data_i;
    div0   = op_i[2] && (rs2_data_i == '0);
    ovf    = (op_in == MD_DIV || op_in == MD_REM) && (rs2_data_i == '1) &&
             (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}});
    fast   = EARLY_OUT && (div0 || ovf);
    accept = (state_q == MD_IDLE) && start_i && !flush_i;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    result_d = result_q;
    rs1_d    = rs1_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    stall_o  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        stall_o = accept;
        if (accept) begin
          op_d   = op_in;
          rd_d   = rd_i;
          rs1_d  = rs1_data_i;
          qneg_d = s1 ^ s2;
          rneg_d = s1;
          div0_d = div0;
          if (fast) begin
            state_d = MD_DONE;
            // op_i[1] selects remainder; overflow quotient equals rs1 itself.
            if (div0) result_d = op_i[1] ? rs1_data_i : '1;
            else      result_d = op_i[1] ? '0 : rs1_data_i;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        stall_o = !flush_i;
        if (flush_i) begin
          state_d = MD_IDLE;
        end else if (last) begin
          state_d  = MD_DONE;
          result_d = fix_sign(op_q, acc_nxt, qneg_q, rneg_q, div0_q, rs1_q);
        end
      end
      default: state_d = MD_IDLE;
    endcase
    done_o   = (state_q == MD_DONE) && !flush_i;
    result_o = result_q;
    rd_o     = rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      rd_q     <= '0;
      result_q <= '0;
      rs1_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rs1_q    <= rs1_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
    end
  end

  muldiv_iter_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    (state_q == MD_CALC),
    .is_div_i  (op_i[2]),
    .a_i       (a_mag),
    .b_i       (b_mag),
    .acc_nxt_o (acc_nxt),
    .last_o    (last)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random operations
// compared against an arithmetic reference model, plus flush and reset cases.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .XLEN      (32),
    .CNT_W     (6),
    .EARLY_OUT (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_i       (rd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_o       (rd_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics straight from 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = sa * sb;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1 with the unit idle; that cycle is cycle 0.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    int          exp_lat, done_cyc;
    logic [31:0] exp_res, got_res;
    logic [4:0]  got_rd;
    bit          stall_ok;
    exp_res  = ref_result(op, a, b);
    exp_lat  = ref_latency(op, a, b);
    done_cyc = -1;
    stall_ok = 1'b1;
    got_res  = '0;
    got_rd   = '0;
    start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_i = rd;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (stall_o !== (c < exp_lat)) stall_ok = 1'b0;
      if (done_o === 1'b1) begin
        done_cyc = c;
        got_res  = result_o;
        got_rd   = rd_o;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    check({tag, "_latency"}, 64'(done_cyc), 64'(exp_lat));
    check({tag, "_stall"}, 64'(stall_ok), 64'(1));
    check({tag, "_result"}, 64'(got_res), 64'(exp_res));
    check({tag, "_rd"}, 64'(got_rd), 64'(rd));
    check({tag, "_hold"}, 64'(result_o), 64'(exp_res));
  endtask

  initial begin
    int  seen;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
    rs1_data_i = '0; rs2_data_i = '0; rd_i = '0;
    #2;
    check("reset_stall", 64'(stall_o), 64'(0));
    check("reset_done", 64'(done_o), 64'(0));
    check("reset_result", 64'(result_o), 64'(0));
    check("reset_rd", 64'(rd_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd9, "mul_7xm3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh_min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h2, 5'd3, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFEC, 32'h3, 5'd4, "div_m20_3");
    run_op(3'd6, 32'hFFFF_FFEC, 32'h3, 5'd5, "rem_m20_3");
    run_op(3'd5, 32'd100, 32'd7, 5'd6, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 5'd7, "remu_100_7");
    run_op(3'd5, 32'd5, 32'd0, 5'd8, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, 5'd10, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf");

    // Flush a DIV in its cycle 10, then start a MUL in cycle 11.
    seen = 0;
    start_i = 1'b1; op_i = 3'd4; rs1_data_i = 32'hFFFF_FFEC; rs2_data_i = 32'd3; rd_i = 5'd13;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush_i = 1'b1;
      @(negedge clk);
      if (done_o !== 1'b0) seen++;
      if (c == 10) check("flush_stall", 64'(stall_o), 64'(0));
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    flush_i = 1'b0;
    check("flush_no_done", 64'(seen), 64'(0));
    run_op(3'd0, 32'd3, 32'd4, 5'd14, "mul_after_flush");

    // Reset in cycle 15 of a MUL, then a flushed start in idle.
    start_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'h1234; rs2_data_i = 32'h5678; rd_i = 5'd15;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_stall", 64'(stall_o), 64'(0));
    check("midrst_done", 64'(done_o), 64'(0));
    check("midrst_result", 64'(result_o), 64'(0));
    check("midrst_rd", 64'(rd_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd9; rs2_data_i = 32'd2; rd_i = 5'd16;
    @(negedge clk);
    check("idle_flush_stall", 64'(stall_o), 64'(0));
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || stall_o !== 1'b0) seen++;
    end
    check("quiet_after_rst_flush", 64'(seen), 64'(0));
    @(posedge clk); #1;
    run_op(3'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 5'd17, "mulh_after_rst");

    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
             5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
